// File: rtl/vregfile_stride_mp.sv
// vregfile_stride_mp: flop-based stride/base register file for the vector memory unit.
//   clk, reset     : clock (rising edge), asynchronous active-high reset
//   a_reg/a_en     : per-port read index and enable; port p uses slice p of each bus
//   a_readdataout  : registered read data, one cycle after the enable, held when disabled
//   c_reg/c_writedatain/c_we : write port
//   i_reg/i_incr/i_en        : in-place post-increment port (write wins on a collision)
// RDW_NEWDATA selects whether a same-edge read sees pre-edge (0) or post-edge (1) contents.
module vregfile_stride_mp #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NUMREGS     = 8,
  parameter int unsigned LOG2NUMREGS = 3,
  parameter int unsigned NUMRDPORTS  = 2,
  parameter int unsigned RDW_NEWDATA = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUMRDPORTS*LOG2NUMREGS-1:0] a_reg,
  input  logic [NUMRDPORTS-1:0]             a_en,
  output logic [NUMRDPORTS*WIDTH-1:0]       a_readdataout,
  input  logic [LOG2NUMREGS-1:0]            c_reg,
  input  logic [WIDTH-1:0]                  c_writedatain,
  input  logic                              c_we,
  input  logic [LOG2NUMREGS-1:0]            i_reg,
  input  logic [WIDTH-1:0]                  i_incr,
  input  logic                              i_en
);

  logic [WIDTH-1:0]       regs     [NUMREGS];
  logic [WIDTH-1:0]       regs_nxt [NUMREGS];
  logic [LOG2NUMREGS-1:0] rd_idx   [NUMRDPORTS];
  logic [WIDTH-1:0]       rd_val   [NUMRDPORTS];

  // Next contents: increment first, then the write overrides it on a collision.
  // Only existing entries are decoded, so out-of-range writes/increments fall away.
  always_comb begin
    for (int r = 0; r < int'(NUMREGS); r++) begin
      regs_nxt[r] = regs[r];
      if (i_en && (i_reg == LOG2NUMREGS'(r)))
        regs_nxt[r] = regs[r] + i_incr;
      if (c_we && (c_reg == LOG2NUMREGS'(r)))
        regs_nxt[r] = c_writedatain;
    end
  end

  // Read mux per port; an index with no matching entry reads as zero.
  always_comb begin
    for (int p = 0; p < int'(NUMRDPORTS); p++) begin
      rd_idx[p] = a_reg[p*LOG2NUMREGS +: LOG2NUMREGS];
      rd_val[p] = '0;
      for (int r = 0; r < int'(NUMREGS); r++) begin
        if (rd_idx[p] == LOG2NUMREGS'(r))
          rd_val[p] = (RDW_NEWDATA != 0) ? regs_nxt[r] : regs[r];
      end
    end
  end

  // Register storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < int'(NUMREGS); r++)
        regs[r] <= '0;
    end else begin
      for (int r = 0; r < int'(NUMREGS); r++)
        regs[r] <= regs_nxt[r];
    end
  end

  // Registered read outputs; a disabled port holds its last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_readdataout <= '0;
    end else begin
      for (int p = 0; p < int'(NUMRDPORTS); p++) begin
        if (a_en[p])
          a_readdataout[p*WIDTH +: WIDTH] <= rd_val[p];
      end
    end
  end

endmodule

// File: tb/tb_vregfile_stride_mp.sv
// Self-checking bench for vregfile_stride_mp. Two instances share the stimulus:
//   dut_a : defaults (8 regs, old-data read-during-write)
//   dut_b : 6 regs with 3-bit indices (regs 6/7 out of range), new-data read-during-write
module tb_vregfile_stride_mp;

  logic        clk;
  logic        reset;
  logic [5:0]  a_reg;
  logic [1:0]  a_en;
  logic [2:0]  c_reg;
  logic [31:0] c_writedatain;
  logic        c_we;
  logic [2:0]  i_reg;
  logic [31:0] i_incr;
  logic        i_en;
  logic [63:0] out_a;
  logic [63:0] out_b;

  int checks;
  int errors;

  vregfile_stride_mp dut_a (
    .clk(clk), .reset(reset), .a_reg(a_reg), .a_en(a_en), .a_readdataout(out_a),
    .c_reg(c_reg), .c_writedatain(c_writedatain), .c_we(c_we),
    .i_reg(i_reg), .i_incr(i_incr), .i_en(i_en)
  );

  vregfile_stride_mp #(.NUMREGS(6), .RDW_NEWDATA(1)) dut_b (
    .clk(clk), .reset(reset), .a_reg(a_reg), .a_en(a_en), .a_readdataout(out_b),
    .c_reg(c_reg), .c_writedatain(c_writedatain), .c_we(c_we),
    .i_reg(i_reg), .i_incr(i_incr), .i_en(i_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        c_we;
    logic [2:0]  c_reg;
    logic [31:0] c_data;
    logic        i_en;
    logic [2:0]  i_reg;
    logic [31:0] i_incr;
    logic [1:0]  a_en;
    logic [2:0]  a0;
    logic [2:0]  a1;
    logic [31:0] x0;  // dut_a port0
    logic [31:0] x1;  // dut_a port1
    logic [31:0] y0;  // dut_b port0
    logic [31:0] y1;  // dut_b port1
  } vec_t;

  typedef struct {
    int          tag;
    logic [31:0] x0, x1, y0, y1;
  } exp_t;

  localparam int NV = 20;
  vec_t vec [NV];
  exp_t sb [$];

  task automatic check(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%h expected=%h", name, tag, act, exp);
    end
  endtask

  // Drive one vector at the falling edge, queue its expectation, and
  // compare just after the next rising edge.
  task automatic apply(input int tag, input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    c_we = v.c_we; c_reg = v.c_reg; c_writedatain = v.c_data;
    i_en = v.i_en; i_reg = v.i_reg; i_incr = v.i_incr;
    a_en = v.a_en; a_reg = {v.a1, v.a0};
    e.tag = tag; e.x0 = v.x0; e.x1 = v.x1; e.y0 = v.y0; e.y1 = v.y1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty vec=%0d got=0 expected=1", tag);
    end else begin
      got = sb.pop_front();
      check("a_port0", got.tag, out_a[31:0],  got.x0);
      check("a_port1", got.tag, out_a[63:32], got.x1);
      check("b_port0", got.tag, out_b[31:0],  got.y0);
      check("b_port1", got.tag, out_b[63:32], got.y1);
    end
  endtask

  task automatic idle_inputs();
    c_we = 1'b0; c_reg = 3'd0; c_writedatain = 32'd0;
    i_en = 1'b0; i_reg = 3'd0; i_incr = 32'd0;
    a_en = 2'b00; a_reg = 6'd0;
  endtask

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;

    //            we   creg  cdata           ie   ireg  incr            aen    a0    a1    x0            x1            y0            y1
    vec[0]  = '{1'b0, 3'd0, 32'h0,          1'b0, 3'd0, 32'h0,          2'b11, 3'd0, 3'd7, 32'h0,        32'h0,        32'h0,        32'h0};
    vec[1]  = '{1'b1, 3'd3, 32'h100,        1'b0, 3'd0, 32'h0,          2'b01, 3'd3, 3'd0, 32'h0,        32'h0,        32'h100,      32'h0};
    vec[2]  = '{1'b0, 3'd0, 32'h0,          1'b1, 3'd3, 32'h20,         2'b00, 3'd0, 3'd0, 32'h0,        32'h0,        32'h100,      32'h0};
    vec[3]  = '{1'b0, 3'd0, 32'h0,          1'b1, 3'd3, 32'h20,         2'b10, 3'd0, 3'd3, 32'h0,        32'h120,      32'h100,      32'h140};
    vec[4]  = '{1'b0, 3'd0, 32'h0,          1'b0, 3'd0, 32'h0,          2'b11, 3'd3, 3'd3, 32'h140,      32'h140,      32'h140,      32'h140};
    vec[5]  = '{1'b1, 3'd5, 32'hFFFFFFF0,   1'b0, 3'd0, 32'h0,          2'b00, 3'd0, 3'd0, 32'h140,      32'h140,      32'h140,      32'h140};
    vec[6]  = '{1'b0, 3'd0, 32'h0,          1'b1, 3'd5, 32'h20,         2'b01, 3'd5, 3'd0, 32'hFFFFFFF0, 32'h140,      32'h10,       32'h140};
    vec[7]  = '{1'b0, 3'd0, 32'h0,          1'b1, 3'd5, 32'hFFFFFFFF,   2'b10, 3'd0, 3'd5, 32'hFFFFFFF0, 32'h10,       32'h10,       32'hF};
    vec[8]  = '{1'b0, 3'd0, 32'h0,          1'b0, 3'd0, 32'h0,          2'b01, 3'd5, 3'd0, 32'hF,        32'h10,       32'hF,        32'hF};
    vec[9]  = '{1'b1, 3'd2, 32'hAAAA,       1'b1, 3'd2, 32'h1,          2'b01, 3'd2, 3'd0, 32'h0,        32'h10,       32'hAAAA,     32'hF};
    vec[10] = '{1'b0, 3'd0, 32'h0,          1'b0, 3'd0, 32'h0,          2'b01, 3'd2, 3'd0, 32'hAAAA,     32'h10,       32'hAAAA,     32'hF};
    vec[11] = '{1'b1, 3'd2, 32'h5,          1'b1, 3'd4, 32'h7,          2'b11, 3'd2, 3'd4, 32'hAAAA,     32'h0,        32'h5,        32'h7};
    vec[12] = '{1'b0, 3'd0, 32'h0,          1'b0, 3'd0, 32'h0,          2'b11, 3'd2, 3'd4, 32'h5,        32'h7,        32'h5,        32'h7};
    vec[13] = '{1'b1, 3'd1, 32'h10,         1'b0, 3'd0, 32'h0,          2'b00, 3'd0, 3'd0, 32'h5,        32'h7,        32'h5,        32'h7};
    vec[14] = '{1'b1, 3'd1, 32'h20,         1'b0, 3'd0, 32'h0,          2'b01, 3'd1, 3'd0, 32'h10,       32'h7,        32'h20,       32'h7};
    vec[15] = '{1'b1, 3'd7, 32'h77,         1'b0, 3'd0, 32'h0,          2'b00, 3'd0, 3'd0, 32'h10,       32'h7,        32'h20,       32'h7};
    vec[16] = '{1'b0, 3'd0, 32'h0,          1'b0, 3'd0, 32'h0,          2'b11, 3'd7, 3'd7, 32'h77,       32'h77,       32'h0,        32'h0};
    vec[17] = '{1'b1, 3'd6, 32'h66,         1'b0, 3'd0, 32'h0,          2'b11, 3'd6, 3'd6, 32'h0,        32'h0,        32'h0,        32'h0};
    vec[18] = '{1'b0, 3'd0, 32'h0,          1'b1, 3'd6, 32'h3,          2'b11, 3'd6, 3'd0, 32'h66,       32'h0,        32'h0,        32'h0};
    vec[19] = '{1'b0, 3'd0, 32'h0,          1'b0, 3'd0, 32'h0,          2'b11, 3'd6, 3'd7, 32'h69,       32'h77,       32'h0,        32'h0};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Every register on both ports reads zero after reset.
    for (int r = 0; r < 8; r++) begin
      v = '{1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 2'b11, 3'(r), 3'(7 - r),
            32'h0, 32'h0, 32'h0, 32'h0};
      apply(100 + r, v);
    end

    for (int i = 0; i < NV; i++) apply(i, vec[i]);

    // Mid-stream reset: outputs clear before any clock edge, and the write
    // pending while reset is high never lands.
    @(negedge clk);
    c_we = 1'b1; c_reg = 3'd0; c_writedatain = 32'h1234;
    i_en = 1'b1; i_reg = 3'd3; i_incr = 32'h1;
    a_en = 2'b11; a_reg = {3'd3, 3'd0};
    reset = 1'b1;
    #1;
    check("rst_async_a", 200, out_a[31:0] | out_a[63:32], 32'h0);
    check("rst_async_b", 200, out_b[31:0] | out_b[63:32], 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_a", 201, out_a[31:0] | out_a[63:32], 32'h0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;

    v = '{1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 2'b11, 3'd0, 3'd3,
          32'h0, 32'h0, 32'h0, 32'h0};
    apply(202, v);
    v = '{1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 2'b11, 3'd5, 3'd7,
          32'h0, 32'h0, 32'h0, 32'h0};
    apply(203, v);

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
